seq_addsub: RTL and testbench



---
 rtl/seq_addsub_if.sv | 28 ++
 rtl/seq_addsub.sv | 123 ++++++++++++
 tb/tb_seq_addsub.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub: valid/ready on both sides plus flush.
// The master drives operands and out_ready; the slave (the adder) drives ready, result and flags.
interface seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, flush, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, flush, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per clock with the carry held between cycles.
// Latency NCHUNK cycles from accept to out_valid; one operation per NCHUNK+2 cycles, no bypass.
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_addsub_if.slave   io
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] beff_q, beff_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;

  assign chunk_sum  = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
                    + {1'b0, beff_q[idx_q*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (idx_q == IW'(NCHUNK - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    beff_d      = beff_q;
    s_d         = s_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    // flush wins over both accept and the result handshake; result regs are left alone
    if (io.flush) begin
      state_d     = IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            a_d        = io.a;
            beff_d     = io.sub ? ~io.b : io.b;
            carry_d    = io.ci;
            idx_d      = '0;
            state_d    = RUN;
            in_ready_d = 1'b0;
          end
        end
        RUN: begin
          s_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
          carry_d = chunk_sum[CHUNK];
          idx_d   = idx_q + 1'b1;
          if (last_chunk) begin
            // overflow: operands agree in sign but the result's MSB disagrees
            co_d        = chunk_sum[CHUNK];
            ovf_d       = (a_q[WIDTH-1] == beff_q[WIDTH-1]) &&
                          (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
            idx_d       = '0;
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      beff_q      <= '0;
      s_q         <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      beff_q      <= beff_d;
      s_q         <= s_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.s         = s_q;
  assign io.co        = co_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed cases on the 16/4 instance, then a random sweep over
// four parameterisations driven in lockstep and checked against an arithmetic model.
module tb_seq_addsub;
  logic        clk;
  logic        rst_n;
  logic        in_valid_r, ci_r, sub_r, flush_r, out_ready_r;
  logic [15:0] a_r, b_r;
  int          tests, failed;

  seq_addsub_if #(.WIDTH(16)) i0 ();
  seq_addsub_if #(.WIDTH(16)) i1 ();
  seq_addsub_if #(.WIDTH(16)) i2 ();
  seq_addsub_if #(.WIDTH(8))  i3 ();

  assign i0.in_valid = in_valid_r;  assign i0.a = a_r;  assign i0.b = b_r;
  assign i0.ci = ci_r;  assign i0.sub = sub_r;  assign i0.flush = flush_r;  assign i0.out_ready = out_ready_r;
  assign i1.in_valid = in_valid_r;  assign i1.a = a_r;  assign i1.b = b_r;
  assign i1.ci = ci_r;  assign i1.sub = sub_r;  assign i1.flush = flush_r;  assign i1.out_ready = out_ready_r;
  assign i2.in_valid = in_valid_r;  assign i2.a = a_r;  assign i2.b = b_r;
  assign i2.ci = ci_r;  assign i2.sub = sub_r;  assign i2.flush = flush_r;  assign i2.out_ready = out_ready_r;
  assign i3.in_valid = in_valid_r;  assign i3.a = a_r[7:0];  assign i3.b = b_r[7:0];
  assign i3.ci = ci_r;  assign i3.sub = sub_r;  assign i3.flush = flush_r;  assign i3.out_ready = out_ready_r;

  seq_addsub #(.WIDTH(16), .CHUNK(4))  u0 (.clk(clk), .rst_n(rst_n), .io(i0));
  seq_addsub #(.WIDTH(16), .CHUNK(1))  u1 (.clk(clk), .rst_n(rst_n), .io(i1));
  seq_addsub #(.WIDTH(16), .CHUNK(16)) u2 (.clk(clk), .rst_n(rst_n), .io(i2));
  seq_addsub #(.WIDTH(8),  .CHUNK(2))  u3 (.clk(clk), .rst_n(rst_n), .io(i3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, co, s} from plain integer arithmetic modulo 2^w
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sub);
    int mask, aa, bb, sum, s, am, bm, sm;
    logic co, ov;
    mask = (1 << w) - 1;
    aa   = int'(a) & mask;
    bb   = (sub ? ~int'(b) : int'(b)) & mask;
    sum  = aa + bb + int'(ci);
    s    = sum & mask;
    co   = ((sum >> w) & 1) == 1;
    am   = (aa >> (w - 1)) & 1;
    bm   = (bb >> (w - 1)) & 1;
    sm   = (s  >> (w - 1)) & 1;
    ov   = (am == bm) && (sm != am);
    return {ov, co, s[15:0]};
  endfunction

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub);
    a_r = a;  b_r = b;  ci_r = ci;  sub_r = sub;
    in_valid_r = 1'b1;
    step();
    in_valid_r = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      step();
      if (i0.out_valid === 1'b1) lat = c;
    end
  endtask

  task automatic drain();
    in_valid_r  = 1'b0;
    flush_r     = 1'b0;
    out_ready_r = 1'b1;
    repeat (20) step();
    out_ready_r = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sub,
                          input logic [15:0] es, input logic eco, input logic eov);
    int lat;
    accept(a, b, ci, sub);
    wait_done(lat);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_s"}, i0.s, es);
    chk({tag, "_co"}, i0.co, eco);
    chk({tag, "_ovf"}, i0.ovf, eov);
    drain();
  endtask

  task automatic chk_sweep(input int k, input int w, input int nch, input int lat,
                           input logic [15:0] s, input logic co, input logic ovf,
                           input logic [17:0] exp);
    chk($sformatf("sweep%0d_lat", k), lat, nch);
    chk($sformatf("sweep%0d_s", k), s, exp[15:0] & 16'((1 << w) - 1));
    chk($sformatf("sweep%0d_co", k), co, exp[16]);
    chk($sformatf("sweep%0d_ovf", k), ovf, exp[17]);
  endtask

  initial begin
    int lat;
    int lats [4];
    logic [15:0] held;
    tests = 0;  failed = 0;
    in_valid_r = 0;  a_r = 0;  b_r = 0;  ci_r = 0;  sub_r = 0;  flush_r = 0;  out_ready_r = 0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", i0.in_ready, 1);
    chk("rst_out_valid", i0.out_valid, 0);
    chk("rst_s", i0.s, 0);
    chk("rst_co", i0.co, 0);
    chk("rst_ovf", i0.ovf, 0);
    rst_n = 1'b1;
    step();

    // Carry ripples across every chunk; result must hold until out_ready
    accept(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("t1_busy", i0.in_ready, 0);
    wait_done(lat);
    chk("t1_lat", lat, 4);
    chk("t1_s", i0.s, 16'h0000);
    chk("t1_co", i0.co, 1);
    chk("t1_ovf", i0.ovf, 0);
    repeat (3) begin
      step();
      chk("t1_hold_vld", i0.out_valid, 1);
      chk("t1_hold_s", i0.s, 16'h0000);
    end
    out_ready_r = 1'b1;
    step();
    out_ready_r = 1'b0;
    chk("t1_hs_vld", i0.out_valid, 0);
    chk("t1_hs_rdy", i0.in_ready, 1);
    drain();

    directed("t2a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("t2b", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    directed("t3a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("t3b", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure in DONE with a new operand waiting
    accept(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done(lat);
    chk("t4_lat", lat, 4);
    a_r = 16'h0F0F;  b_r = 16'h0101;  ci_r = 0;  sub_r = 0;
    in_valid_r = 1'b1;
    repeat (5) begin
      step();
      chk("t4_vld", i0.out_valid, 1);
      chk("t4_rdy", i0.in_ready, 0);
      chk("t4_s", i0.s, 16'h2345);
      chk("t4_co", i0.co, 0);
    end
    out_ready_r = 1'b1;
    step();
    out_ready_r = 1'b0;
    chk("t4_hs_vld", i0.out_valid, 0);
    chk("t4_no_bypass", i0.in_ready, 1);
    step();
    in_valid_r = 1'b0;
    chk("t4_accept2", i0.in_ready, 0);
    wait_done(lat);
    chk("t4_lat2", lat, 4);
    chk("t4_s2", i0.s, 16'h1010);
    drain();

    // Async reset in the middle of RUN
    accept(16'hABCD, 16'h1357, 1'b1, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t5r_vld", i0.out_valid, 0);
    chk("t5r_rdy", i0.in_ready, 1);
    chk("t5r_s", i0.s, 0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("t5r_no_result", i0.out_valid, 0);
    chk("t5r_idle", i0.in_ready, 1);

    // Flush in DONE drops the result but keeps s
    accept(16'h0102, 16'h0304, 1'b0, 1'b0);
    wait_done(lat);
    chk("t5f_lat", lat, 4);
    held = i0.s;
    chk("t5f_s", held, 16'h0406);
    flush_r = 1'b1;
    step();
    flush_r = 1'b0;
    chk("t5f_vld", i0.out_valid, 0);
    chk("t5f_rdy", i0.in_ready, 1);
    chk("t5f_s_kept", i0.s, 16'h0406);
    // flush beats a simultaneous accept
    in_valid_r = 1'b1;  flush_r = 1'b1;
    step();
    in_valid_r = 1'b0;  flush_r = 1'b0;
    chk("t5f_prio", i0.in_ready, 1);
    drain();

    // Random sweep, all four instances accept together
    for (int n = 0; n < 200; n++) begin
      logic [17:0] e16, e8;
      a_r = 16'($urandom);  b_r = 16'($urandom);
      ci_r = 1'($urandom);  sub_r = 1'($urandom);
      e16 = ref_op(16, a_r, b_r, ci_r, sub_r);
      e8  = ref_op(8, a_r, b_r, ci_r, sub_r);
      in_valid_r = 1'b1;
      step();
      in_valid_r = 1'b0;
      for (int k = 0; k < 4; k++) lats[k] = 0;
      for (int c = 1; c <= 20; c++) begin
        step();
        if (lats[0] == 0 && i0.out_valid === 1'b1) lats[0] = c;
        if (lats[1] == 0 && i1.out_valid === 1'b1) lats[1] = c;
        if (lats[2] == 0 && i2.out_valid === 1'b1) lats[2] = c;
        if (lats[3] == 0 && i3.out_valid === 1'b1) lats[3] = c;
      end
      chk_sweep(0, 16, 4,  lats[0], i0.s, i0.co, i0.ovf, e16);
      chk_sweep(1, 16, 16, lats[1], i1.s, i1.co, i1.ovf, e16);
      chk_sweep(2, 16, 1,  lats[2], i2.s, i2.co, i2.ovf, e16);
      chk_sweep(3, 8,  4,  lats[3], {8'h00, i3.s}, i3.co, i3.ovf, e8);
      out_ready_r = 1'b1;
      step();
      out_ready_r = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
